// File: rtl/prog_loader_pkg.sv
// Shared definitions for the boot-time program loader: FSM states,
// CPU reset polarity and stream word geometry.
package prog_loader_pkg;

    typedef enum logic [2:0] {
        HDR     = 3'd0,
        LOAD    = 3'd1,
        CSUM    = 3'd2,
        RELEASE = 3'd3,
        RUN     = 3'd4,
        ERROR   = 3'd5
    } state_e;

    localparam logic RstEnable  = 1'b1;
    localparam logic RstDisable = 1'b0;

    localparam int WordBytes = 4;

endpackage

// File: rtl/prog_loader_byte_assembler.sv
// Gathers little-endian bytes into 32-bit words; flags the word as the
// final byte is accepted so the caller can register it one cycle later.
module prog_loader_byte_assembler
    import prog_loader_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        clear_i,
    input  logic        byte_valid_i,
    input  logic [7:0]  byte_i,
    output logic        word_valid_o,
    output logic [31:0] word_o
);

    // Only three bytes need storing; the fourth is the live input byte.
    logic [23:0] shift_q;
    logic [1:0]  byteCnt_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            shift_q   <= '0;
            byteCnt_q <= '0;
        end else if (clear_i) begin
            shift_q   <= '0;
            byteCnt_q <= '0;
        end else if (byte_valid_i) begin
            shift_q   <= {byte_i, shift_q[23:8]};
            byteCnt_q <= byteCnt_q + 2'd1;
        end
    end

    assign word_valid_o = byte_valid_i && (byteCnt_q == 2'(WordBytes - 1));
    assign word_o       = {byte_i, shift_q};

endmodule

// File: rtl/prog_loader.sv
// Loads a checksummed program image from a byte stream into instruction ROM
// and holds the CPU in reset until the image has been verified.
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int ADDR_W        = 10,
    parameter int RELEASE_DELAY = 4
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              rx_valid_i,
    input  logic [7:0]        rx_data_i,
    output logic              rx_ready_o,
    input  logic              reload_i,
    output logic              rom_we_o,
    output logic [ADDR_W-1:0] rom_addr_o,
    output logic [31:0]       rom_wdata_o,
    output logic              cpu_rst_o,
    output logic              done_o,
    output logic              err_o
);

    localparam logic [31:0] MaxWords = 32'd1 << ADDR_W;

    state_e            state_q;
    logic              rxReady_q;
    logic              romWe_q;
    logic [ADDR_W-1:0] romAddr_q;
    logic [31:0]       romWdata_q;
    logic              cpuRst_q;
    logic              done_q;
    logic              err_q;
    logic [ADDR_W:0]   nWords_q;
    logic [ADDR_W:0]   wordCnt_q;
    logic [ADDR_W:0]   wordCnt_d;
    logic [7:0]        csum_q;
    logic [15:0]       delay_q;

    logic              accept;
    logic              asmValid;
    logic              restart;
    logic              wordValid;
    logic [31:0]       word;

    assign accept    = rx_valid_i & rxReady_q;
    assign asmValid  = accept & ((state_q == HDR) | (state_q == LOAD));
    assign restart   = reload_i & ((state_q == RUN) | (state_q == ERROR));
    assign wordCnt_d = wordCnt_q + 1'b1;

    prog_loader_byte_assembler u_assembler (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .clear_i      (restart),
        .byte_valid_i (asmValid),
        .byte_i       (rx_data_i),
        .word_valid_o (wordValid),
        .word_o       (word)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= HDR;
            rxReady_q  <= 1'b0;
            romWe_q    <= 1'b0;
            romAddr_q  <= '0;
            romWdata_q <= '0;
            cpuRst_q   <= RstEnable;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            nWords_q   <= '0;
            wordCnt_q  <= '0;
            csum_q     <= '0;
            delay_q    <= '0;
        end else begin
            romWe_q <= 1'b0;
            if (asmValid) begin
                csum_q <= csum_q ^ rx_data_i;
            end
            case (state_q)
                HDR: begin
                    rxReady_q <= 1'b1;
                    if (wordValid) begin
                        nWords_q  <= word[ADDR_W:0];
                        wordCnt_q <= '0;
                        if (word > MaxWords) begin
                            state_q   <= ERROR;
                            err_q     <= 1'b1;
                            rxReady_q <= 1'b0;
                        end else if (word == 32'd0) begin
                            state_q <= CSUM;
                        end else begin
                            state_q <= LOAD;
                        end
                    end
                end
                LOAD: begin
                    rxReady_q <= 1'b1;
                    if (wordValid) begin
                        romWe_q    <= 1'b1;
                        romAddr_q  <= wordCnt_q[ADDR_W-1:0];
                        romWdata_q <= word;
                        wordCnt_q  <= wordCnt_d;
                        if (wordCnt_d == nWords_q) begin
                            state_q <= CSUM;
                        end
                    end
                end
                CSUM: begin
                    rxReady_q <= 1'b1;
                    if (accept) begin
                        rxReady_q <= 1'b0;
                        if (rx_data_i == csum_q) begin
                            state_q <= RELEASE;
                            delay_q <= 16'(RELEASE_DELAY);
                        end else begin
                            state_q <= ERROR;
                            err_q   <= 1'b1;
                        end
                    end
                end
                RELEASE: begin
                    delay_q <= delay_q - 16'd1;
                    if (delay_q == 16'd1) begin
                        state_q  <= RUN;
                        cpuRst_q <= RstDisable;
                        done_q   <= 1'b1;
                    end
                end
                RUN, ERROR: begin
                    // Reload wipes load progress but leaves ROM contents alone.
                    if (restart) begin
                        state_q   <= HDR;
                        rxReady_q <= 1'b1;
                        cpuRst_q  <= RstEnable;
                        done_q    <= 1'b0;
                        err_q     <= 1'b0;
                        csum_q    <= '0;
                        nWords_q  <= '0;
                        wordCnt_q <= '0;
                    end
                end
                default: begin
                    state_q <= HDR;
                end
            endcase
        end
    end

    assign rx_ready_o  = rxReady_q;
    assign rom_we_o    = romWe_q;
    assign rom_addr_o  = romAddr_q;
    assign rom_wdata_o = romWdata_q;
    assign cpu_rst_o   = cpuRst_q;
    assign done_o      = done_q;
    assign err_o       = err_q;

endmodule

// File: doc/prog_loader.md
Name: prog_loader

Overview:
- Boot stage directly upstream of the minimal SOPC.
- Accepts a byte stream containing a program image and writes it word-by-word into the instruction ROM.
- Holds the CPU in reset until the image is loaded and its checksum is verified, then releases the CPU after a fixed delay.
- Replaces the fixed-time reset release that is currently driven from outside the SOPC.

Parameters:
- ADDR_W, 10: width of the ROM word index. ROM depth is 2**ADDR_W words.
- RELEASE_DELAY, 4: number of cycles between checksum pass and cpu_rst deassertion. Must be ≥1.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- rx_valid  in  1  rx_data holds a valid byte.
- rx_data  in  8  stream byte.
- rx_ready  out  1  loader can accept a byte. A transfer occurs when rx_valid & rx_ready are both high at a rising edge.
- reload  in  1  single-cycle pulse that restarts loading. Honoured only in RUN or ERROR.
- rom_we  out  1  ROM write strobe, one cycle per word.
- rom_addr  out  ADDR_W  ROM word index.
- rom_wdata  out  32  ROM write data.
- cpu_rst  out  1  active-high reset to the SOPC (1 = RstEnable).
- done  out  1  image loaded and CPU released.
- err  out  1  load failed.

Behaviour:
- Reset values (rst low): state=HDR, rx_ready=0, rom_we=0, rom_addr=0, rom_wdata=0, cpu_rst=1, done=0, err=0. All internal counters, the byte shift register and the checksum accumulator are 0.
- Stream format:
  - 4-byte word count N, little-endian.
  - N words, 4 bytes each, little-endian (first byte = bits 7:0).
  - 1 checksum byte = XOR of all header and payload bytes.
- rx_ready is registered: 1 in HDR, LOAD and CSUM; 0 in RELEASE, RUN and ERROR. It goes high the first cycle after reset deasserts.
- Every accepted header and payload byte is XORed into the checksum accumulator.
- HDR state:
  - Collects 4 bytes into N (32 bit).
  - After the 4th byte: if N > 2**ADDR_W go to ERROR. If N == 0 go to CSUM. Otherwise go to LOAD with word_cnt=0.
- LOAD state:
  - Shifts in bytes; a byte counter runs 0..3.
  - On acceptance of byte 3, the next cycle has rom_we=1, rom_wdata=assembled word, rom_addr=word_cnt. That is 1-cycle latency from the final byte edge to the write strobe.
  - word_cnt then increments.
  - When word_cnt reaches N, go to CSUM.
  - The strobe cycle does not stall rx_ready; back-to-back bytes are accepted.
  - rom_we is 0 in all other cycles. rom_addr and rom_wdata hold their last values.
- CSUM state:
  - Accepts 1 byte and compares it with the accumulator.
  - Match: go to RELEASE with delay counter = RELEASE_DELAY.
  - Mismatch: go to ERROR.
- RELEASE state:
  - Counts down; cpu_rst stays 1.
  - When the count reaches 0, go to RUN. cpu_rst=0 and done=1 take effect in the same cycle RUN is entered.
- RUN state: cpu_rst=0, done=1. rx bytes are ignored (not accepted).
- ERROR state: cpu_rst=1, err=1. Sticky until reload or rst.
- reload in RUN or ERROR:
  - Next cycle: cpu_rst=1, done=0, err=0, state=HDR.
  - The checksum accumulator, N, word_cnt and byte counters are cleared.
  - reload in any other state is ignored.
- Asynchronous rst mid-load: returns immediately to the reset values. ROM contents are not cleared; a partial image remains but the CPU stays in reset.
- A word count of exactly 2**ADDR_W is legal. rom_addr wraps to 0 only after the last word, and the wrapped value is never written.

Decomposition:
- Shared package / define file:
  - State encodings: HDR, LOAD, CSUM, RELEASE, RUN, ERROR (3 bit).
  - Reuse RstEnable/RstDisable for cpu_rst polarity.
  - New `WordBytes = 4`.
- One natural sub-module: byte_assembler. It holds the 4-byte shift register and the 2-bit byte counter, and produces a word_valid pulse plus the 32-bit word. It is shared by the HDR and LOAD phases.

Test Plan:
- Normal load:
  - Stimulus: N=2, words 0x34011100 and 0x34020020, checksum 0x30.
  - Required response: rom_we pulses at addr 0 (0x34011100) and addr 1 (0x34020020). cpu_rst falls 4 cycles after the checksum byte is accepted. done=1, err=0.
- Bad checksum:
  - Stimulus: same stream as the normal load, but checksum 0x31.
  - Required response: both words written, then err=1, cpu_rst held at 1, rx_ready=0. A following reload plus a correct stream gives done=1.
- Empty and oversize images:
  - Stimulus A: N=0, checksum 0x00. Required response: no rom_we, done=1.
  - Stimulus B: N=0x00000401 with ADDR_W=10. Required response: err=1 right after the header, no rom_we ever.
- Flow control:
  - Stimulus: rx_valid toggled randomly, including 1-cycle gaps between bytes of the same word.
  - Required response: words identical to the normal-load case, exactly one rom_we per word.
- Reset mid-load:
  - Stimulus: drive rst low after byte 2 of word 1, then restart with the full normal-load stream.
  - Required response: outputs return to their reset values immediately (asynchronously). The reloaded image completes with done=1.
- Ignore after run:
  - Stimulus: send bytes while in RUN.
  - Required response: rx_ready=0 throughout, no rom_we, cpu_rst stays 0.
